// File: rtl/sr_unit.sv
// sr_unit: CPU status register (R2) holder and interrupt/RETI SR sequencer.
// Arbitrates the SR source mux word against direct R2 writes, pushes and
// clears SR on interrupt entry, restores SR from the stack on RETI.
// Optional macro SR_RSVD_MASK_EN: forces SR[15:9] to zero on every load.
module sr_unit #(
  parameter int               SR_W      = 16,
  parameter logic [SR_W-1:0]  KEEP_MASK = 16'h0040
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SR_W-1:0] reg_SR_in,
  input  logic            SR_ld,
  input  logic            SR_bus_wr,
  input  logic [SR_W-1:0] SR_bus_data,
  input  logic            irq_req,
  input  logic            reti,
  input  logic            push_ready,
  input  logic            pop_valid,
  input  logic [SR_W-1:0] pop_data,
  output logic [SR_W-1:0] reg_SR_out,
  output logic            push_valid,
  output logic [SR_W-1:0] push_data,
  output logic            pop_req,
  output logic            irq_ack,
  output logic            busy,
  output logic            GIE,
  output logic            cpu_off
);

  localparam int GIE_BIT    = 3;
  localparam int CPUOFF_BIT = 4;

  // Mask applied to every SR load; reserved bits drop out when enabled.
`ifdef SR_RSVD_MASK_EN
  localparam logic [SR_W-1:0] LOAD_MASK = SR_W'(16'h01FF);
`else
  localparam logic [SR_W-1:0] LOAD_MASK = '1;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PUSH  = 2'd1,
    S_CLEAR = 2'd2,
    S_POP   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [SR_W-1:0] sr_q, sr_d;

  // State and SR registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
    end
  end

  // Next state and next SR. Loads are only honoured in IDLE; while the
  // sequencer owns the SR, flag updates and bus writes are dropped.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    unique case (state_q)
      S_IDLE: begin
        if (reti) begin
          state_d = S_POP;
        end else if (irq_req && sr_q[GIE_BIT]) begin
          state_d = S_PUSH;
        end else if (SR_bus_wr) begin
          sr_d = SR_bus_data & LOAD_MASK;
        end else if (SR_ld) begin
          sr_d = reg_SR_in & LOAD_MASK;
        end
      end
      S_PUSH: begin
        // Committed once entered: a dropped irq_req does not abort.
        if (push_ready) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        // Clearing GIE/CPUOFF wakes the core for the handler.
        sr_d    = sr_q & KEEP_MASK;
        state_d = S_IDLE;
      end
      S_POP: begin
        if (pop_valid) begin
          sr_d    = pop_data & LOAD_MASK;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs are pure decodes of registered state.
  always_comb begin
    push_valid = (state_q == S_PUSH);
    push_data  = (state_q == S_PUSH) ? sr_q : '0;
    pop_req    = (state_q == S_POP);
    irq_ack    = (state_q == S_CLEAR);
    busy       = (state_q != S_IDLE);
  end

  // Status taps for the interrupt controller and clock gating.
  always_comb begin
    reg_SR_out = sr_q;
    GIE        = sr_q[GIE_BIT];
    cpu_off    = sr_q[CPUOFF_BIT];
  end

endmodule

// File: tb/tb_sr_unit.sv
// tb_sr_unit: scoreboard bench for sr_unit.
module tb_sr_unit;

  localparam logic [15:0] KEEP = 16'h0040;
`ifdef SR_RSVD_MASK_EN
  localparam logic [15:0] LMASK = 16'h01FF;
`else
  localparam logic [15:0] LMASK = 16'hFFFF;
`endif

  logic        clk, rst_n;
  logic [15:0] reg_SR_in, SR_bus_data, pop_data;
  logic        SR_ld, SR_bus_wr, irq_req, reti, push_ready, pop_valid;
  logic [15:0] reg_SR_out, push_data;
  logic        push_valid, pop_req, irq_ack, busy, GIE, cpu_off;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_sr_q[$];
  logic [15:0] exp_push_q[$];

  sr_unit dut (
    .clk(clk), .rst_n(rst_n),
    .reg_SR_in(reg_SR_in), .SR_ld(SR_ld),
    .SR_bus_wr(SR_bus_wr), .SR_bus_data(SR_bus_data),
    .irq_req(irq_req), .reti(reti),
    .push_ready(push_ready), .pop_valid(pop_valid), .pop_data(pop_data),
    .reg_SR_out(reg_SR_out), .push_valid(push_valid), .push_data(push_data),
    .pop_req(pop_req), .irq_ack(irq_ack), .busy(busy),
    .GIE(GIE), .cpu_off(cpu_off)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_sr(input logic [15:0] v);
    exp_sr_q.push_back(v);
  endtask

  task automatic check_sr(input string tag);
    logic [15:0] e;
    if (exp_sr_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = exp_sr_q.pop_front();
      chk(tag, reg_SR_out, e);
    end
  endtask

  task automatic bus_wr(input logic [15:0] v, input string tag);
    SR_bus_wr   = 1'b1;
    SR_bus_data = v;
    expect_sr(v & LMASK);
    step();
    SR_bus_wr = 1'b0;
    check_sr(tag);
  endtask

  initial begin
    int npop;
    logic [15:0] e;
    rst_n = 1'b0; reg_SR_in = '0; SR_bus_data = '0; pop_data = '0;
    SR_ld = 0; SR_bus_wr = 0; irq_req = 0; reti = 0; push_ready = 0; pop_valid = 0;

    // Reset values
    #3;
    chk("rst_sr", reg_SR_out, 16'h0000);
    chk("rst_pv", push_valid, 0);
    chk("rst_pd", push_data, 16'h0000);
    chk("rst_pr", pop_req, 0);
    chk("rst_ack", irq_ack, 0);
    chk("rst_busy", busy, 0);
    #10 rst_n = 1'b1;
    step();

    // Bus write beats mux load in the same cycle
    SR_ld = 1; reg_SR_in = 16'h0103; SR_bus_wr = 1; SR_bus_data = 16'h0008;
    expect_sr(16'h0008);
    step();
    SR_ld = 0; SR_bus_wr = 0;
    check_sr("prio_sr");
    chk("prio_gie", GIE, 1);

    // Plain mux load
    SR_ld = 1; reg_SR_in = 16'h0103;
    expect_sr(16'h0103 & LMASK);
    step();
    SR_ld = 0;
    check_sr("ld_sr");
    chk("ld_gie", GIE, 0);

    // Reserved-bit behaviour on a full-width bus write
    bus_wr(16'hFFFF, "rsvd_sr");
    chk("rsvd_cpuoff", cpu_off, 1);

    // Interrupt entry with push back-pressure
    bus_wr(16'h0058, "irq_setup");
    irq_req = 1;
    exp_push_q.push_back(16'h0058);
    step();
    irq_req = 0;
    for (int i = 0; i < 4; i++) begin
      chk("push_valid", push_valid, 1);
      chk("push_hold", push_data, 16'h0058);
      chk("push_busy", busy, 1);
      chk("push_noack", irq_ack, 0);
      SR_ld = (i == 1); reg_SR_in = 16'hFFFF;
      push_ready = (i == 3);
      if (push_valid && push_ready) begin
        e = exp_push_q.pop_front();
        chk("push_data", push_data, e);
      end
      step();
    end
    push_ready = 0; SR_ld = 0;
    chk("push_sb_drained", exp_push_q.size(), 0);
    chk("clr_ack", irq_ack, 1);
    chk("clr_pv", push_valid, 0);
    chk("clr_sr_held", reg_SR_out, 16'h0058);
    expect_sr(16'h0058 & KEEP);
    step();
    check_sr("clr_sr");
    chk("clr_ack_off", irq_ack, 0);
    chk("clr_cpuoff", cpu_off, 0);
    chk("clr_gie", GIE, 0);
    chk("clr_busy", busy, 0);

    // Masked interrupt while asleep
    bus_wr(16'h0010, "mask_setup");
    irq_req = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mask_pv", push_valid, 0);
      chk("mask_ack", irq_ack, 0);
      chk("mask_busy", busy, 0);
      chk("mask_cpuoff", cpu_off, 1);
    end
    irq_req = 0;

    // RETI beats irq_req; delayed pop_valid; SR_ld ignored while popping
    bus_wr(16'h0018, "reti_setup");
    reti = 1; irq_req = 1;
    step();
    reti = 0; irq_req = 0;
    npop = 0;
    for (int i = 0; i < 3; i++) begin
      chk("reti_nopush", push_valid, 0);
      if (pop_req) npop++;
      SR_ld = (i < 2); reg_SR_in = 16'hABCD;
      pop_valid = (i == 2); pop_data = 16'h0019;
      if (i == 2) expect_sr(16'h0019 & LMASK);
      step();
    end
    SR_ld = 0; pop_valid = 0;
    chk("reti_popreq_cycles", npop, 3);
    chk("reti_popreq_off", pop_req, 0);
    check_sr("reti_sr");
    chk("reti_busy", busy, 0);
    chk("reti_cpuoff", cpu_off, 1);
    chk("reti_gie", GIE, 1);

    // Pop of a word with reserved bits set
    reti = 1;
    step();
    reti = 0; pop_valid = 1; pop_data = 16'hFE5A;
    expect_sr(16'hFE5A & LMASK);
    step();
    pop_valid = 0;
    check_sr("pop_rsvd_sr");

    // Async reset in the middle of a push
    irq_req = 1;
    step();
    irq_req = 0;
    chk("mid_pv", push_valid, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_sr", reg_SR_out, 16'h0000);
    chk("arst_pv", push_valid, 0);
    chk("arst_busy", busy, 0);
    #3 rst_n = 1'b1;
    push_ready = 1;
    step();
    chk("post_busy", busy, 0);
    chk("post_ack", irq_ack, 0);
    push_ready = 0;
    bus_wr(16'h0008, "post_wr");

    chk("sb_drained", exp_sr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
